cpu_run_monitor: RTL and testbench
==================================

Name: cpu_run_monitor

Overview:
Synthesizable run monitor that sits beside the cpu core's retire and store interface. It moves self-checking out of the testbench into RTL, so the same checks run in simulation and on FPGA. It counts cycles from start, detects the end sentinel (jal x0,0), enforces a cycle budget, and tracks NUM_CHECKS parametrised value/expect lanes with sticky hit flags and first-hit cycle stamps. It also counts stores and misaligned stores, and produces a single pass/fail verdict.

Parameters:
NUM_CHECKS, 4, number of independent check lanes (1..16)
DATA_WIDTH, 32, width of the instruction, PC, store data and check values
CYCLE_WIDTH, 16, width of the cycle counter and hit stamps
MAX_CYCLES, 20, cycle budget before timeout (1..2^CYCLE_WIDTH-1)
END_SENTINEL, 32'h0000_006F, instruction encoding that terminates a run

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins or restarts a run
retire_valid  in  1  an instruction retires this cycle
retire_pc  in  DATA_WIDTH  PC of the retiring instruction
retire_instr  in  DATA_WIDTH  encoding of the retiring instruction
store_valid  in  1  a store commits this cycle
store_addr  in  DATA_WIDTH  byte address of the store
chk_en  in  NUM_CHECKS  per-lane enable, sampled while running
chk_value  in  NUM_CHECKS*DATA_WIDTH  observed values (register or memory taps), lane i at [i*DATA_WIDTH +: DATA_WIDTH]
chk_expect  in  NUM_CHECKS*DATA_WIDTH  expected values, same packing as chk_value
state  out  2  00 IDLE, 01 RUN, 10 ENDED, 11 TIMEOUT
done  out  1  high in ENDED or TIMEOUT
pass  out  1  verdict, valid when done is high
cycle_count  out  CYCLE_WIDTH  number of RUN cycles elapsed
end_pc  out  DATA_WIDTH  PC at which the sentinel retired
chk_hit  out  NUM_CHECKS  sticky per-lane match flags
chk_hit_cycle  out  NUM_CHECKS*CYCLE_WIDTH  cycle_count value at each lane's first match
store_count  out  CYCLE_WIDTH  stores committed during the run, saturating
misalign_count  out  8  stores with store_addr[1:0] != 0, saturating at 255

Behaviour:
- Reset (reset=0, asynchronous) forces every output to 0 and the state to IDLE.
- IDLE -> RUN when start=1. On that edge the monitor clears cycle_count, chk_hit, chk_hit_cycle, store_count, misalign_count and end_pc.
- RUN:
  - cycle_count increments by 1 every cycle; the first RUN cycle is cycle 0.
  - For each lane i with chk_en[i]=1, chk_hit[i]=0 and value==expect: set chk_hit[i] and write the current cycle_count to chk_hit_cycle[i]. Later matches do not change the stamp. Disabled lanes never set.
  - store_valid increments store_count. If store_addr[1:0]!=0 it also increments misalign_count.
- RUN -> ENDED when retire_valid=1 and retire_instr==END_SENTINEL. end_pc latches retire_pc.
- RUN -> TIMEOUT when no sentinel retires in a cycle where cycle_count==MAX_CYCLES-1.
- If the sentinel retires in the last budget cycle, ENDED wins.
- Lane matches, store counting and misalignment counting in the terminating cycle are all recorded.
- ENDED and TIMEOUT hold every output frozen. start re-enters RUN with the same clears as IDLE->RUN.
- start while in RUN is ignored.
- pass = (state==ENDED) AND ((chk_hit & chk_en)==chk_en) AND the alignment rule (see Optional Feature).
  - pass is registered and is 0 whenever done=0.
  - TIMEOUT always gives pass=0.
- Counters saturate; they never wrap.
- Reset asserted mid-run aborts the run immediately and returns to IDLE with all outputs cleared.

Optional Feature:
- Macro CPU_MON_STRICT_ALIGN_EN.
- Defined: any misaligned store makes pass=0.
- Undefined: misalign_count is still maintained but does not affect pass.

Decomposition:
- Package cpu_mon_pkg holds:
  - the state encoding constants (IDLE, RUN, ENDED, TIMEOUT)
  - the default END_SENTINEL constant (32'h0000_006F)
  - the misalign counter width (8)
- One sub-module, cpu_mon_check_lane, instantiated NUM_CHECKS times via generate. Each instance holds one sticky hit flag and one stamp register. It takes clear, run, en, value and expect as inputs.

Test Plan:
- Sentinel end: start, retire 4 NOPs, then retire_instr=0x0000006F at pc 0x10 -> state=ENDED, done=1, end_pc=0x10, cycle_count=5.
- Check lanes: lane0 expect 0x10 with value reaching 0x10 at cycle 2; lane1 expect 0xDEADBEEF with value matching at cycle 3; sentinel at cycle 6 -> chk_hit=0b0011, stamps 2 and 3, pass=1. Repeat with lane1 never matching -> pass=0.
- Timeout: MAX_CYCLES=20, no sentinel -> TIMEOUT entered after cycle 19, cycle_count=20, pass=0. Sentinel exactly at cycle 19 -> ENDED.
- Misalignment: store at addr 0x41 plus an aligned store at 0x40 -> store_count=2, misalign_count=1. With CPU_MON_STRICT_ALIGN_EN defined, pass=0 despite all checks hit; without it, pass=1.
- Restart and reset: after ENDED, a new start clears chk_hit and counts from 0. Asserting reset=0 in the middle of a run gives state=IDLE on the same edge with all outputs 0. start pulses during RUN leave cycle_count unaffected.

Source files
------------

// File: rtl/cpu_mon_pkg.sv
// Shared constants for the cpu run monitor: state encoding, default end
// sentinel (jal x0,0) and misalign counter width.
// Optional build macro used by the top: CPU_MON_STRICT_ALIGN_EN.
package cpu_mon_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_ENDED   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam logic [31:0] END_SENTINEL_DEFAULT = 32'h0000_006F;

    localparam int unsigned MISALIGN_WIDTH = 8;

endpackage

// File: rtl/cpu_mon_check_lane.sv
// One check lane: sticky match flag plus the cycle stamp of the first match.
module cpu_mon_check_lane
    import cpu_mon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CYCLE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   en,
    input  logic [DATA_WIDTH-1:0]  value,
    input  logic [DATA_WIDTH-1:0]  expect_value,
    input  logic [CYCLE_WIDTH-1:0] cycle,
    output logic                   hit,
    output logic [CYCLE_WIDTH-1:0] hit_cycle,
    output logic                   hit_next_c
);

    logic                   hit_q, hit_d;
    logic [CYCLE_WIDTH-1:0] stamp_q, stamp_d;
    logic                   match_c;

    // First enabled match while running sets the flag and captures the stamp.
    always_comb begin
        hit_d   = hit_q;
        stamp_d = stamp_q;
        match_c = run && en && !hit_q && (value == expect_value);
        if (clear) begin
            hit_d   = 1'b0;
            stamp_d = '0;
        end else if (match_c) begin
            hit_d   = 1'b1;
            stamp_d = cycle;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q   <= 1'b0;
            stamp_q <= '0;
        end else begin
            hit_q   <= hit_d;
            stamp_q <= stamp_d;
        end
    end

    assign hit        = hit_q;
    assign hit_cycle  = stamp_q;
    assign hit_next_c = hit_d;

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor beside the core retire/store interface: cycle budget, end
// sentinel detection, check lanes, store counters and a registered verdict.
// Build macro CPU_MON_STRICT_ALIGN_EN: any misaligned store fails the run.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int unsigned           NUM_CHECKS   = 4,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           CYCLE_WIDTH  = 16,
    parameter int unsigned           MAX_CYCLES   = 20,
    parameter logic [DATA_WIDTH-1:0] END_SENTINEL = DATA_WIDTH'(END_SENTINEL_DEFAULT)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              retire_valid,
    input  logic [DATA_WIDTH-1:0]             retire_pc,
    input  logic [DATA_WIDTH-1:0]             retire_instr,
    input  logic                              store_valid,
    input  logic [DATA_WIDTH-1:0]             store_addr,
    input  logic [NUM_CHECKS-1:0]             chk_en,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]  chk_value,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]  chk_expect,
    output logic [1:0]                        state,
    output logic                              done,
    output logic                              pass,
    output logic [CYCLE_WIDTH-1:0]            cycle_count,
    output logic [DATA_WIDTH-1:0]             end_pc,
    output logic [NUM_CHECKS-1:0]             chk_hit,
    output logic [NUM_CHECKS*CYCLE_WIDTH-1:0] chk_hit_cycle,
    output logic [CYCLE_WIDTH-1:0]            store_count,
    output logic [MISALIGN_WIDTH-1:0]         misalign_count
);

    logic [1:0]                state_q, state_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
    logic [CYCLE_WIDTH-1:0]    cycle_q, cycle_d;
    logic [DATA_WIDTH-1:0]     end_pc_q, end_pc_d;
    logic [CYCLE_WIDTH-1:0]    store_q, store_d;
    logic [MISALIGN_WIDTH-1:0] mis_q, mis_d;
    logic                      lane_clear_c;
    logic                      lane_run_c;
    logic                      sentinel_c;
    logic                      align_ok_c;
    logic [NUM_CHECKS-1:0]     hit_next_c;
    logic                      unused_store_addr_c;

    // Only the two low address bits matter for alignment.
    assign unused_store_addr_c = ^store_addr[DATA_WIDTH-1:2];

    assign sentinel_c = retire_valid && (retire_instr == END_SENTINEL);

    // Check lanes.
    for (genvar i = 0; i < int'(NUM_CHECKS); i++) begin : g_lane
        cpu_mon_check_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .CYCLE_WIDTH (CYCLE_WIDTH)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clear        (lane_clear_c),
            .run          (lane_run_c),
            .en           (chk_en[i]),
            .value        (chk_value[i*DATA_WIDTH +: DATA_WIDTH]),
            .expect_value (chk_expect[i*DATA_WIDTH +: DATA_WIDTH]),
            .cycle        (cycle_q),
            .hit          (chk_hit[i]),
            .hit_cycle    (chk_hit_cycle[i*CYCLE_WIDTH +: CYCLE_WIDTH]),
            .hit_next_c   (hit_next_c[i])
        );
    end

    // Run FSM, saturating counters and verdict.
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        pass_d       = pass_q;
        cycle_d      = cycle_q;
        end_pc_d     = end_pc_q;
        store_d      = store_q;
        mis_d        = mis_q;
        lane_clear_c = 1'b0;
        lane_run_c   = 1'b0;
        align_ok_c   = 1'b1;

        case (state_q)
            ST_RUN: begin
                lane_run_c = 1'b1;
                if (cycle_q != '1) cycle_d = cycle_q + CYCLE_WIDTH'(1);
                if (store_valid) begin
                    if (store_q != '1) store_d = store_q + CYCLE_WIDTH'(1);
                    if ((store_addr[1:0] != 2'b00) && (mis_q != '1))
                        mis_d = mis_q + MISALIGN_WIDTH'(1);
                end
`ifdef CPU_MON_STRICT_ALIGN_EN
                align_ok_c = (mis_d == '0);
`else
                align_ok_c = 1'b1;
`endif
                // Sentinel takes priority over an expiring budget.
                if (sentinel_c) begin
                    state_d  = ST_ENDED;
                    done_d   = 1'b1;
                    end_pc_d = retire_pc;
                    pass_d   = ((hit_next_c & chk_en) == chk_en) && align_ok_c;
                end else if (cycle_q == CYCLE_WIDTH'(MAX_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            default: begin
                if (start) begin
                    state_d      = ST_RUN;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    cycle_d      = '0;
                    end_pc_d     = '0;
                    store_d      = '0;
                    mis_d        = '0;
                    lane_clear_c = 1'b1;
                end
            end
        endcase
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            cycle_q  <= '0;
            end_pc_q <= '0;
            store_q  <= '0;
            mis_q    <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            cycle_q  <= cycle_d;
            end_pc_q <= end_pc_d;
            store_q  <= store_d;
            mis_q    <= mis_d;
        end
    end

    assign state          = state_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign cycle_count    = cycle_q;
    assign end_pc         = end_pc_q;
    assign store_count    = store_q;
    assign misalign_count = mis_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed plan steps followed by random traffic,
// all checked against an event-level reference model of a run.
module tb_cpu_run_monitor;

    localparam int NC   = 4;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int MAXC = 20;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SENT = 32'h0000_006F;
`ifdef CPU_MON_STRICT_ALIGN_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, retire_valid, store_valid;
    logic [DW-1:0]     retire_pc, retire_instr, store_addr;
    logic [NC-1:0]     chk_en;
    logic [NC*DW-1:0]  chk_value, chk_expect;
    logic [1:0]        state;
    logic              done, pass;
    logic [CW-1:0]     cycle_count, store_count;
    logic [DW-1:0]     end_pc;
    logic [NC-1:0]     chk_hit;
    logic [NC*CW-1:0]  chk_hit_cycle;
    logic [7:0]        misalign_count;

    cpu_run_monitor #(
        .NUM_CHECKS(NC), .DATA_WIDTH(DW), .CYCLE_WIDTH(CW), .MAX_CYCLES(MAXC),
        .END_SENTINEL(SENT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
        .store_valid(store_valid), .store_addr(store_addr),
        .chk_en(chk_en), .chk_value(chk_value), .chk_expect(chk_expect),
        .state(state), .done(done), .pass(pass), .cycle_count(cycle_count),
        .end_pc(end_pc), .chk_hit(chk_hit), .chk_hit_cycle(chk_hit_cycle),
        .store_count(store_count), .misalign_count(misalign_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase 0 idle, 1 running, 2 ended, 3 timed out.
    int            m_phase;
    int            m_elapsed;
    bit [NC-1:0]   m_hit;
    int            m_stamp [NC];
    int            m_stores, m_mis;
    logic [31:0]   m_endpc;
    bit            m_pass;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_phase = 0; m_elapsed = 0; m_hit = '0; m_stores = 0; m_mis = 0;
        m_endpc = '0; m_pass = 1'b0;
        foreach (m_stamp[i]) m_stamp[i] = 0;
    endtask

    // Apply the run rules to the inputs present before the coming edge.
    task automatic model_step();
        int now;
        if (m_phase != 1) begin
            if (start) begin
                model_clear();
                m_phase = 1;
            end
            return;
        end
        now = m_elapsed;
        for (int i = 0; i < NC; i++)
            if (chk_en[i] && !m_hit[i] &&
                chk_value[i*DW +: DW] == chk_expect[i*DW +: DW]) begin
                m_hit[i] = 1'b1;
                m_stamp[i] = now;
            end
        if (store_valid) begin
            if (m_stores < 65535) m_stores++;
            if (store_addr[1:0] != 2'b00 && m_mis < 255) m_mis++;
        end
        if (m_elapsed < 65535) m_elapsed++;
        if (retire_valid && retire_instr == SENT) begin
            m_phase = 2;
            m_endpc = retire_pc;
            m_pass  = ((m_hit & chk_en) == chk_en) && !(STRICT && m_mis != 0);
        end else if (now == MAXC - 1) begin
            m_phase = 3;
            m_pass  = 1'b0;
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".state"}, 64'(state), 64'(m_phase));
        check({tag, ".done"}, 64'(done), 64'(m_phase >= 2));
        check({tag, ".pass"}, 64'(pass), 64'(m_pass));
        check({tag, ".cycle"}, 64'(cycle_count), 64'(m_elapsed));
        check({tag, ".end_pc"}, 64'(end_pc), 64'(m_endpc));
        check({tag, ".hit"}, 64'(chk_hit), 64'(m_hit));
        for (int i = 0; i < NC; i++)
            check($sformatf("%s.stamp%0d", tag, i), 64'(chk_hit_cycle[i*CW +: CW]),
                  64'(m_stamp[i]));
        check({tag, ".stores"}, 64'(store_count), 64'(m_stores));
        check({tag, ".misalign"}, 64'(misalign_count), 64'(m_mis));
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        start = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_instr = '0;
        store_valid = 1'b0; store_addr = '0;
    endtask

    task automatic set_lane(int i, logic [31:0] v, logic [31:0] e);
        chk_value[i*DW +: DW]  = v;
        chk_expect[i*DW +: DW] = e;
    endtask

    // Asynchronous reset issued between clock edges.
    task automatic async_reset(string tag);
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        check_all(tag);
        check({tag, ".idle"}, 64'(state), 64'(2'b00));
        #1;
        reset = 1'b1;
    endtask

    task automatic run_lanes(string tag, bit lane1_ok);
        quiet();
        chk_en = 4'b0011;
        start = 1'b1;
        tick({tag, ".start"});
        start = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            set_lane(0, 32'(c * 8), 32'h10);
            set_lane(1, (lane1_ok && c == 3) ? 32'hDEAD_BEEF : 32'h1234, 32'hDEAD_BEEF);
            set_lane(2, 32'h55, 32'h55);
            set_lane(3, 32'h0, 32'h1);
            retire_valid = 1'b1;
            retire_pc    = 32'(c * 4);
            retire_instr = (c == 6) ? SENT : NOP;
            tick($sformatf("%s.c%0d", tag, c));
        end
        quiet();
        check({tag, ".hit_exp"}, 64'(chk_hit), lane1_ok ? 64'h3 : 64'h1);
        check({tag, ".stamp0_exp"}, 64'(chk_hit_cycle[0 +: CW]), 64'd2);
        check({tag, ".pass_exp"}, 64'(pass), 64'(lane1_ok));
        if (lane1_ok) check({tag, ".stamp1_exp"}, 64'(chk_hit_cycle[CW +: CW]), 64'd3);
    endtask

    initial begin
        reset = 1'b0;
        quiet();
        chk_en = '0; chk_value = '0; chk_expect = '0;
        model_clear();
        #1;
        check_all("por");
        @(posedge clk);
        #1;
        check_all("por_edge");
        reset = 1'b1;

        // Sentinel end after four NOPs.
        start = 1'b1;
        tick("sent.start");
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            retire_valid = 1'b1;
            retire_pc    = 32'(c * 4);
            retire_instr = (c == 4) ? SENT : NOP;
            tick($sformatf("sent.c%0d", c));
        end
        quiet();
        check("sent.state_exp", 64'(state), 64'(2'b10));
        check("sent.cycle_exp", 64'(cycle_count), 64'd5);
        check("sent.pc_exp", 64'(end_pc), 64'h10);
        tick("sent.hold");

        // Check lanes, then restart with lane1 never matching.
        run_lanes("lanes_ok", 1'b1);
        tick("lanes_ok.hold");
        run_lanes("lanes_bad", 1'b0);

        // Timeout with no sentinel.
        chk_en = '0;
        start = 1'b1;
        tick("tmo.start");
        start = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            retire_valid = 1'b1; retire_instr = NOP;
            tick($sformatf("tmo.c%0d", c));
        end
        quiet();
        check("tmo.state_exp", 64'(state), 64'(2'b11));
        check("tmo.cycle_exp", 64'(cycle_count), 64'd20);
        check("tmo.pass_exp", 64'(pass), 64'd0);

        // Sentinel in the last budget cycle wins.
        start = 1'b1;
        tick("last.start");
        start = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            retire_valid = 1'b1; retire_pc = 32'h100; retire_instr = (c == MAXC - 1) ? SENT : NOP;
            tick($sformatf("last.c%0d", c));
        end
        quiet();
        check("last.state_exp", 64'(state), 64'(2'b10));
        check("last.pass_exp", 64'(pass), 64'd1);

        // Misaligned plus aligned store, start pulses during the run.
        chk_en = 4'b0001;
        set_lane(0, 32'h7, 32'h7);
        start = 1'b1;
        tick("mis.start");
        start = 1'b0;
        store_valid = 1'b1; store_addr = 32'h41; start = 1'b1;
        tick("mis.c0");
        store_addr = 32'h40;
        tick("mis.c1");
        quiet();
        retire_valid = 1'b1; retire_pc = 32'h20; retire_instr = SENT;
        tick("mis.c2");
        quiet();
        check("mis.stores_exp", 64'(store_count), 64'd2);
        check("mis.mis_exp", 64'(misalign_count), 64'd1);
        check("mis.cycle_exp", 64'(cycle_count), 64'd3);
        check("mis.pass_exp", 64'(pass), STRICT ? 64'd0 : 64'd1);

        // Restart clears, then reset mid-run.
        start = 1'b1;
        tick("rst.start");
        start = 1'b0;
        check("rst.hit_clr", 64'(chk_hit), 64'd0);
        check("rst.cycle_clr", 64'(cycle_count), 64'd0);
        for (int c = 0; c < 3; c++) tick($sformatf("rst.c%0d", c));
        async_reset("rst.mid");
        tick("rst.after");

        // Random traffic.
        for (int i = 0; i < NC; i++) set_lane(i, 32'h0, 32'($urandom_range(0, 3)));
        for (int n = 0; n < 1500; n++) begin
            start        = ($urandom_range(0, 24) == 0);
            retire_valid = 1'($urandom);
            retire_pc    = $urandom;
            retire_instr = ($urandom_range(0, 11) == 0) ? SENT : $urandom;
            store_valid  = 1'($urandom);
            store_addr   = $urandom;
            if ($urandom_range(0, 9) == 0) chk_en = 4'($urandom);
            for (int i = 0; i < NC; i++) chk_value[i*DW +: DW] = 32'($urandom_range(0, 7));
            tick("rand");
            if ($urandom_range(0, 299) == 0) async_reset("rand.rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
